vlog_statmchs_sum3_drv: RTL and testbench
=========================================

// Module: vlog_statmchs_sum3_drv
// PURPOSE
//  Initiator for the vlog_statmchs_sum3 operand-sum protocol (start/d in, ready/sum out).
//  Accepts one request holding NUM_OPS operand words and pulses start.
//  Streams the operands on d, one per clk, then waits for ready and captures sum.
//  Checks the captured sum against a locally accumulated expected sum.
//  Reports one response per request; used as on-chip stimulus source and self-checker.
// PARAMETERS
//  NUM_OPS  3   operands per transaction (>=2)
//  DW       8   operand / sum width
//  TIMEOUT  16  max clk cycles in WAIT before a timeout response (>=1)
// PORTS
//  clk        in   1           single clock, all logic on posedge
//  reset      in   1           synchronous, active-high
//  req_valid  in   1           request present
//  req_ready  out  1           request accepted when req_valid & req_ready
//  req_ops    in   NUM_OPS*DW  operands; op0 in bits [DW-1:0]
//  start      out  1           one-cycle pulse, marks op0 on d
//  d          out  DW          operand bus to summer
//  ready      in   1           summer result valid
//  sum        in   DW          summer result
//  rsp_valid  out  1           one-cycle response strobe
//  rsp_sum    out  DW          captured sum (0 on timeout)
//  rsp_err    out  1           captured sum != expected (valid with rsp_valid)
//  rsp_tmo    out  1           no ready within TIMEOUT (valid with rsp_valid)
//  busy       out  1           FSM not in IDLE
// BEHAVIOUR
//  Reset: all outputs 0 except req_ready=1; FSM->IDLE; op/expected/timeout regs cleared.
//  Reset asserted mid-transaction aborts it: no rsp_valid, start/d forced 0 next edge.
//  FSM states: IDLE, LOAD, FEED, WAIT, RESP.
//  IDLE: req_ready=1. On req_valid: latch req_ops, expected=0, go LOAD.
//  LOAD (1 cycle): start=1, d=op0, expected+=op0, go FEED.
//  FEED (NUM_OPS-1 cycles): start=0, d=op1..op(NUM_OPS-1) in order, expected+=op_k.
//  FEED end -> WAIT, tmo counter=0. d=0 and start=0 in every state but LOAD/FEED.
//  WAIT: ready=1 -> capture sum, go RESP. Else counter++. At counter==TIMEOUT-1 without ready -> RESP.
//  RESP (1 cycle): rsp_valid=1, rsp_sum/rsp_err/rsp_tmo valid. Next state IDLE.
//  Timeout case: rsp_tmo=1, rsp_err=0, rsp_sum=0.
//  Ready seen during LOAD/FEED is stale: ignored, no effect on state.
//  Ready and timeout on the same WAIT cycle: ready wins, rsp_tmo=0.
//  Arithmetic: expected is mod 2^DW; carries are discarded.
//  rsp_err = (sum != expected), compared at DW bits.
//  Latency: accept edge -> start at +1, last operand at +NUM_OPS.
//  Latency: ready sampled at edge N -> rsp_valid during cycle N+1.
//  req_ready=0 from accept through RESP; no request overlap.
//  Next accept is possible on the cycle after RESP.
//  rsp_* fields hold their value until the next RESP.
//  rsp_valid is a single-cycle pulse.
// TESTING
//  1 ops=(0x05,0x0A,0x10); summer returns ready, sum=0x1F after 2 cycles
//    -> start on exactly 1 cycle; d seq 05,0A,10.
//    -> rsp_valid pulse, rsp_sum=0x1F, rsp_err=0, rsp_tmo=0.
//  2 ops=(0xFF,0x02,0x80); sum=0x81
//    -> wrap accepted, rsp_err=0.
//    -> Repeat with sum=0x82: rsp_err=1, rsp_sum=0x82.
//  3 ready never asserted, TIMEOUT=16
//    -> rsp_valid exactly 16 cycles after entering WAIT.
//    -> rsp_tmo=1, rsp_sum=0.
//    -> req_ready back to 1 next cycle.
//  4 ready pulsed during FEED, then again 3 cycles into WAIT with sum=expected
//    -> first pulse ignored, response from second, rsp_err=0.
//  5 reset raised in 2nd FEED cycle
//    -> next edge: start=0, d=0, busy=0, req_ready=1, no rsp_valid.
//    -> New request afterwards completes normally.
//  6 req_valid held high continuously
//    -> back-to-back transactions, one rsp_valid each.
//    -> No start pulse before the prior RESP.

Source files
------------

// File: rtl/vlog_statmchs_sum3_drv.sv
// Operand-sum protocol initiator: streams NUM_OPS operands to a summer, waits for its
// result and reports it together with a mismatch flag against a locally computed sum.
module vlog_statmchs_sum3_drv #(
  parameter int unsigned NUM_OPS = 3,
  parameter int unsigned DW      = 8,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic [NUM_OPS*DW-1:0] i_req_ops,
  output logic                  o_start,
  output logic [DW-1:0]         o_d,
  input  logic                  i_ready,
  input  logic [DW-1:0]         i_sum,
  output logic                  o_rsp_valid,
  output logic [DW-1:0]         o_rsp_sum,
  output logic                  o_rsp_err,
  output logic                  o_rsp_tmo,
  output logic                  o_busy
);

  localparam int unsigned CntMax = (NUM_OPS > TIMEOUT) ? NUM_OPS : TIMEOUT;
  localparam int unsigned CW     = $clog2(CntMax + 1);

  typedef enum logic [2:0] {StIdle, StLoad, StFeed, StWait, StResp} state_e;

  state_e                r_state;
  state_e                w_state_nxt;
  logic [NUM_OPS*DW-1:0] r_ops;
  logic [DW-1:0]         r_exp;
  logic [CW-1:0]         r_cnt;
  logic [DW-1:0]         r_rsp_sum;
  logic                  r_rsp_err;
  logic                  r_rsp_tmo;
  logic                  w_feed_last;
  logic                  w_tmo_hit;
  logic                  w_driving;

  // r_cnt indexes FEED cycles, then is reused as the WAIT timeout counter
  assign w_feed_last = (r_cnt == CW'(NUM_OPS - 2));
  assign w_tmo_hit   = (r_cnt == CW'(TIMEOUT - 1));
  assign w_driving   = (r_state == StLoad) || (r_state == StFeed);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle:  if (i_req_valid) w_state_nxt = StLoad;
      StLoad:  w_state_nxt = StFeed;
      StFeed:  if (w_feed_last) w_state_nxt = StWait;
      StWait:  if (i_ready || w_tmo_hit) w_state_nxt = StResp;
      StResp:  w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_ops     <= '0;
      r_exp     <= '0;
      r_cnt     <= '0;
      r_rsp_sum <= '0;
      r_rsp_err <= 1'b0;
      r_rsp_tmo <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (i_req_valid) begin
            r_ops <= i_req_ops;
            r_exp <= '0;
          end
        end
        StLoad, StFeed: begin
          // The operand on d is always the low word; shift the next one down
          r_ops <= r_ops >> DW;
          r_exp <= r_exp + r_ops[DW-1:0];
          if ((r_state == StLoad) || w_feed_last) begin
            r_cnt <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        StWait: begin
          if (i_ready) begin
            r_rsp_sum <= i_sum;
            r_rsp_err <= (i_sum != r_exp);
            r_rsp_tmo <= 1'b0;
          end else if (w_tmo_hit) begin
            r_rsp_sum <= '0;
            r_rsp_err <= 1'b0;
            r_rsp_tmo <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_req_ready = (r_state == StIdle);
  assign o_busy      = (r_state != StIdle);
  assign o_start     = (r_state == StLoad);
  assign o_d         = w_driving ? r_ops[DW-1:0] : '0;
  assign o_rsp_valid = (r_state == StResp);
  assign o_rsp_sum   = r_rsp_sum;
  assign o_rsp_err   = r_rsp_err;
  assign o_rsp_tmo   = r_rsp_tmo;

endmodule

// File: tb/tb_vlog_statmchs_sum3_drv.sv
// Directed bench for vlog_statmchs_sum3_drv (NUM_OPS=3, DW=8, TIMEOUT=16); inputs are
// driven and outputs sampled on the falling clock edge.
module tb_vlog_statmchs_sum3_drv;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [23:0] req_ops;
  logic        start;
  logic [7:0]  d;
  logic        ready;
  logic [7:0]  sum;
  logic        rsp_valid;
  logic [7:0]  rsp_sum;
  logic        rsp_err;
  logic        rsp_tmo;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  vlog_statmchs_sum3_drv #(
    .NUM_OPS(3),
    .DW     (8),
    .TIMEOUT(16)
  ) dut (
    .i_clk      (clk),
    .i_reset    (reset),
    .i_req_valid(req_valid),
    .o_req_ready(req_ready),
    .i_req_ops  (req_ops),
    .o_start    (start),
    .o_d        (d),
    .i_ready    (ready),
    .i_sum      (sum),
    .o_rsp_valid(rsp_valid),
    .o_rsp_sum  (rsp_sum),
    .o_rsp_err  (rsp_err),
    .o_rsp_tmo  (rsp_tmo),
    .o_busy     (busy)
  );

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full transaction: dly idle WAIT cycles, then the summer answers with s.
  // With stale set, a wrong-valued ready pulse is driven during LOAD and must be ignored.
  task automatic txn(input string tag, input logic [23:0] ops, input int dly,
                     input logic [7:0] s, input logic exp_err, input bit stale);
    req_valid = 1'b1;
    req_ops   = ops;
    tick();
    req_valid = 1'b0;
    chk({tag, "_load_start"}, start, 1);
    chk({tag, "_load_d"}, d, ops[7:0]);
    chk({tag, "_load_rdy"}, req_ready, 0);
    if (stale) begin
      ready = 1'b1;
      sum   = ~s;
    end
    tick();
    ready = 1'b0;
    sum   = 8'h00;
    chk({tag, "_feed1_start"}, start, 0);
    chk({tag, "_feed1_d"}, d, ops[15:8]);
    tick();
    chk({tag, "_feed2_d"}, d, ops[23:16]);
    tick();
    chk({tag, "_wait_d"}, d, 0);
    chk({tag, "_wait_rsp"}, rsp_valid, 0);
    chk({tag, "_wait_busy"}, busy, 1);
    repeat (dly) tick();
    ready = 1'b1;
    sum   = s;
    tick();
    ready = 1'b0;
    sum   = 8'h00;
    chk({tag, "_rsp_valid"}, rsp_valid, 1);
    chk({tag, "_rsp_sum"}, rsp_sum, s);
    chk({tag, "_rsp_err"}, rsp_err, exp_err);
    chk({tag, "_rsp_tmo"}, rsp_tmo, 0);
    tick();
    chk({tag, "_post_valid"}, rsp_valid, 0);
    chk({tag, "_post_rdy"}, req_ready, 1);
    chk({tag, "_post_hold"}, rsp_sum, s);
  endtask

  initial begin
    int n_tmo;
    int n_start;
    int n_rsp;
    bit pending;
    bit prev_rsp;

    reset     = 1'b1;
    req_valid = 1'b0;
    req_ops   = '0;
    ready     = 1'b0;
    sum       = '0;
    tick();
    tick();
    chk("rst_req_ready", req_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_start", start, 0);
    chk("rst_d", d, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_fields", {rsp_sum, rsp_err, rsp_tmo}, 0);
    reset = 1'b0;
    tick();

    // 05+0A+10 = 1F, summer answers after 2 WAIT cycles
    txn("t1", 24'h100A05, 1, 8'h1F, 1'b0, 1'b0);
    // FF+02+80 = 0x181 -> 0x81 mod 256
    txn("t2ok", 24'h8002FF, 0, 8'h81, 1'b0, 1'b0);
    txn("t2bad", 24'h8002FF, 2, 8'h82, 1'b1, 1'b0);

    // Timeout: ready never comes
    req_valid = 1'b1;
    req_ops   = 24'h030201;
    tick();
    req_valid = 1'b0;
    repeat (3) tick();
    n_tmo = 0;
    while (!rsp_valid && n_tmo < 40) begin
      tick();
      n_tmo++;
    end
    chk("t3_tmo_cycles", n_tmo, 16);
    chk("t3_rsp_valid", rsp_valid, 1);
    chk("t3_rsp_tmo", rsp_tmo, 1);
    chk("t3_rsp_err", rsp_err, 0);
    chk("t3_rsp_sum", rsp_sum, 0);
    tick();
    chk("t3_req_ready", req_ready, 1);
    chk("t3_post_valid", rsp_valid, 0);

    // Stale ready during LOAD, real answer 3 cycles into WAIT: 01+02+03 = 06
    txn("t4", 24'h030201, 3, 8'h06, 1'b0, 1'b1);

    // Reset in the 2nd FEED cycle
    req_valid = 1'b1;
    req_ops   = 24'h332211;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    chk("t5_feed2_d", d, 8'h33);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t5_start", start, 0);
    chk("t5_d", d, 0);
    chk("t5_busy", busy, 0);
    chk("t5_req_ready", req_ready, 1);
    chk("t5_rsp_valid", rsp_valid, 0);
    tick();
    chk("t5_rsp_valid2", rsp_valid, 0);
    // 11+22+33 = 66
    txn("t5new", 24'h332211, 0, 8'h66, 1'b0, 1'b0);

    // req_valid and ready held high: 6-cycle back-to-back transactions
    req_valid = 1'b1;
    req_ops   = 24'h030201;
    ready     = 1'b1;
    sum       = 8'h06;
    n_start   = 0;
    n_rsp     = 0;
    pending   = 1'b0;
    prev_rsp  = 1'b0;
    for (int i = 0; i < 30; i++) begin
      chk("t6_overlap", start & pending, 0);
      chk("t6_double_rsp", rsp_valid & prev_rsp, 0);
      if (start) begin
        n_start++;
        pending = 1'b1;
      end
      if (rsp_valid) begin
        n_rsp++;
        pending = 1'b0;
        chk("t6_rsp_err", rsp_err, 0);
      end
      prev_rsp = rsp_valid;
      if (i == 29) begin
        req_valid = 1'b0;
        ready     = 1'b0;
      end
      tick();
    end
    chk("t6_starts", n_start, 5);
    chk("t6_rsps", n_rsp, 5);
    chk("t6_idle", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
